pcie_rx: RTL and testbench
==========================

// Module: pcie_rx
// PURPOSE
//  Receive-side TLP decoder for the 64-bit AXI4-Stream RX port of the 7-series PCIe core.
//  Decodes host MWr/MRd to BAR0 into PIO write strobes and PIO read requests.
//  PIO read requests carry the fields pcie_tx needs to build its completion.
//  Decodes CplD for DMA reads (always READ_REQUEST_BYTES long) into byte-swapped,
//  DW-realigned 64-bit words tagged with request tag and qword index.
//  Everything else is discarded and counted.
// PARAMETERS
//  READ_REQUEST_BYTES  512  size of every DMA read request issued; sets qword index base
// PORTS
//  clock                      in   1   single clock for all logic
//  reset_n                    in   1   asynchronous, active-low reset
//  axis_rx_tvalid             in   1   RX beat valid
//  axis_rx_tdata              in   64  beat; DW0 in [31:0], DW1 in [63:32]
//  axis_rx_tlast              in   1   last beat of TLP
//  axis_rx_tready             out  1   always 1 after reset; no backpressure
//  pio_write_valid            out  1   1-cycle strobe
//  pio_write_address          out  13  qword address = TLP addr[15:3]
//  pio_write_data             out  64  {swap(DW data1), swap(DW data0)}; data1=0 if length 1
//  pio_read_valid             out  1   1-cycle strobe
//  pio_read_address           out  13  TLP addr[15:3]
//  pio_read_rid_tag           out  24  {requester_id[15:0], tag[7:0]}
//  pio_read_lower_addr        out  4   TLP addr[6:3]
//  cpl_valid                  out  1   completion data qword valid
//  cpl_data                   out  64  {swap(DW n+1), swap(DW n)}
//  cpl_tag                    out  8   tag from completion DW2[15:8]
//  cpl_index                  out  6   qword index within the read request
//  cpl_last                   out  1   with cpl_valid: last qword of this completion
//  cpl_error                  out  1   1-cycle strobe; completion truncated by early tlast
//  unsupported_count          out  8   saturating count of dropped TLPs
// BEHAVIOUR
//  Reset: every output 0, including axis_rx_tready; state IDLE.
//   Asynchronous assert, synchronous deassert.
//   axis_rx_tready goes 1 on the first clock after deassert.
//  A beat is consumed only when tvalid=1; tvalid gaps mid-TLP hold state.
//  Header decode: fmt/type = DW0[30:24]; length = DW0[9:0].
//   Decoded types:
//    0x00 MRd32 3DW, 0x20 MRd64 4DW
//    0x40 MWr32 3DW, 0x60 MWr64 4DW
//    0x4A CplD
//  States:
//   IDLE: beat0 {DW1,DW0} latched.
//    MWr/MRd with length 1|2 -> HDR.
//    CplD with status DW1[15:13]=0 and even length -> CPL_HDR.
//    Else -> DROP, unsupported_count+1 (saturates at 255).
//    A beat0 with tlast returns to IDLE.
//   HDR: beat1 latched.
//    3DW: address = DW2; MWr data0 = beat1[63:32].
//    4DW: address = beat1[63:32]; 64-bit address bits [63:32] ignored.
//    MRd -> pio_read_valid the cycle after beat1; then IDLE.
//    MWr32 length 1 -> write now; otherwise -> WDATA.
//   WDATA: remaining data DW(s) latched.
//    pio_write_valid asserts 1 cycle after the beat holding the last data DW.
//   CPL_HDR: beat1 = {data0, DW2}.
//    Tag latched from DW2.
//    cpl_index = (READ_REQUEST_BYTES - byte_count DW1[11:0]) >> 3.
//    data0 held -> CPL_DATA.
//   CPL_DATA: each beat {dB,dA} emits cpl_data = {swap(dA), swap(held)}.
//    dB becomes the new held DW.
//    cpl_index increments per emitted qword, wrapping mod 64.
//    Final qword emitted when remaining DW count = 0; cpl_last=1 on it.
//    The closing beat carries tlast with only its low DW valid.
//   DROP: discard beats until tlast -> IDLE.
//  Output latency: all outputs registered, 1 cycle after the consuming beat.
//  Early tlast:
//   Header/write states: no strobe, count+1, IDLE.
//   CPL_DATA: cpl_error pulses with no further cpl_valid, IDLE.
//  Missing tlast: extra beats after expected end -> DROP until tlast; no second strobe.
//  Reset mid-TLP: state IDLE, partial TLP lost; the next TLP decodes normally.
// TESTING
//  MWr32 addr 0x0000_0048, len 2, data DWs 0x11223344,0x55667788
//   -> pio_write_valid 1 cycle after beat2; addr 9; data 0x8877665544332211.
//  MRd64 addr 0x1_0000_0050, req_id 0x0100, tag 0x07, len 2
//   -> pio_read_valid; addr 10; rid_tag 0x010007; lower_addr 0xA.
//  CplD tag 0x03, len 16, byte_count 512, DW k = k
//   -> 8 qwords, index 0..7, first data {swap(1), swap(0)}; cpl_last on 8th.
//  CplD len 32, byte_count 256 -> first cpl_index 32; last cpl_index 47.
//  CplD len 16 with tlast after 4 beats -> cpl_error pulse; no cpl_last.
//  260 MsgD TLPs -> unsupported_count saturates at 255.
//  reset_n low mid-MWr, then a valid MWr -> only the second write strobes.
//  Random tvalid gaps on all of the above -> identical outputs.

Source files
------------

// File: rtl/pcie_rx.sv
// -----------------------------------------------------------------------------
// pcie_rx
//   Receive-side TLP decoder for the 64-bit AXI4-Stream RX port of the 7-series
//   PCIe core. Host MWr/MRd TLPs to BAR0 become PIO write strobes and PIO read
//   requests. CplD TLPs answering DMA reads become byte-swapped, DW-realigned
//   64-bit words tagged with request tag and qword index. All other TLPs are
//   discarded and counted.
//
// Parameters
//   READ_REQUEST_BYTES  size of every DMA read request; base for cpl_index
//
// Ports
//   clock                in   single clock
//   reset_n              in   asynchronous active-low reset
//   axis_rx_tvalid       in   RX beat valid
//   axis_rx_tdata[63:0]  in   RX beat, DW0 in [31:0], DW1 in [63:32]
//   axis_rx_tlast        in   last beat of TLP
//   axis_rx_tready       out  1 after reset, never backpressures
//   pio_write_valid      out  1-cycle PIO write strobe
//   pio_write_address    out  qword address (TLP addr[15:3])
//   pio_write_data       out  {swap(data1), swap(data0)}
//   pio_read_valid       out  1-cycle PIO read request strobe
//   pio_read_address     out  qword address (TLP addr[15:3])
//   pio_read_rid_tag     out  {requester_id, tag}
//   pio_read_lower_addr  out  TLP addr[6:3]
//   cpl_valid            out  completion data qword valid
//   cpl_data             out  {swap(DW n+1), swap(DW n)}
//   cpl_tag              out  tag of the completion
//   cpl_index            out  qword index within the read request
//   cpl_last             out  last qword of this completion
//   cpl_error            out  1-cycle strobe, completion cut short by tlast
//   unsupported_count    out  saturating count of dropped TLPs
// -----------------------------------------------------------------------------
module pcie_rx #(
   parameter int READ_REQUEST_BYTES = 512
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        axis_rx_tvalid,
   input  logic [63:0] axis_rx_tdata,
   input  logic        axis_rx_tlast,
   output logic        axis_rx_tready,
   output logic        pio_write_valid,
   output logic [12:0] pio_write_address,
   output logic [63:0] pio_write_data,
   output logic        pio_read_valid,
   output logic [12:0] pio_read_address,
   output logic [23:0] pio_read_rid_tag,
   output logic [3:0]  pio_read_lower_addr,
   output logic        cpl_valid,
   output logic [63:0] cpl_data,
   output logic [7:0]  cpl_tag,
   output logic [5:0]  cpl_index,
   output logic        cpl_last,
   output logic        cpl_error,
   output logic [7:0]  unsupported_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_WDATA,
      S_CPL_HDR,
      S_CPL_DATA,
      S_DROP
   } state_t;

   state_t      r_state;
   logic        r_tready;
   logic        r_is_wr;
   logic        r_is_4dw;
   logic        r_len1;
   logic [23:0] r_rid_tag;
   logic [12:0] r_addr;
   logic [31:0] r_wdata0;
   logic [31:0] r_held;
   logic [9:0]  r_rem;
   logic [7:0]  r_tag;
   logic [5:0]  r_index;

   logic        r_pio_write_valid;
   logic [12:0] r_pio_write_address;
   logic [63:0] r_pio_write_data;
   logic        r_pio_read_valid;
   logic [12:0] r_pio_read_address;
   logic [23:0] r_pio_read_rid_tag;
   logic [3:0]  r_pio_read_lower_addr;
   logic        r_cpl_valid;
   logic [63:0] r_cpl_data;
   logic [7:0]  r_cpl_tag;
   logic [5:0]  r_cpl_index;
   logic        r_cpl_last;
   logic        r_cpl_error;
   logic [7:0]  r_unsupported_count;

   function automatic logic [31:0] swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   logic        w_beat;
   logic [31:0] w_dw0;
   logic [31:0] w_dw1;
   logic [6:0]  w_fmt_type;
   logic [9:0]  w_len;
   logic        w_is_mem;
   logic        w_len_ok;
   logic        w_is_cpld;
   logic [5:0]  w_cpl_index;
   logic [12:0] w_hdr_qaddr;

   assign w_beat     = axis_rx_tvalid & r_tready;
   assign w_dw0      = axis_rx_tdata[31:0];
   assign w_dw1      = axis_rx_tdata[63:32];
   assign w_fmt_type = w_dw0[30:24];
   assign w_len      = w_dw0[9:0];
   assign w_is_mem   = (w_fmt_type == 7'h00) || (w_fmt_type == 7'h20) ||
                       (w_fmt_type == 7'h40) || (w_fmt_type == 7'h60);
   assign w_len_ok   = (w_len == 10'd1) || (w_len == 10'd2);
   // CplD accepted only with successful status and an even DW count, so the
   // data always closes on a whole qword.
   assign w_is_cpld  = (w_fmt_type == 7'h4A) && (w_dw1[15:13] == 3'd0) && !w_len[0];
   // Starting qword of this completion within the read request, from the
   // remaining byte count in completion DW1.
   assign w_cpl_index = 6'((32'(READ_REQUEST_BYTES) - {20'd0, w_dw1[11:0]}) >> 3);
   // 3DW header: address is DW2 (low half of beat1); 4DW: address low is DW3.
   assign w_hdr_qaddr = r_is_4dw ? w_dw1[15:3] : w_dw0[15:3];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state               <= S_IDLE;
         r_tready              <= 1'b0;
         r_is_wr               <= 1'b0;
         r_is_4dw              <= 1'b0;
         r_len1                <= 1'b0;
         r_rid_tag             <= '0;
         r_addr                <= '0;
         r_wdata0              <= '0;
         r_held                <= '0;
         r_rem                 <= '0;
         r_tag                 <= '0;
         r_index               <= '0;
         r_pio_write_valid     <= 1'b0;
         r_pio_write_address   <= '0;
         r_pio_write_data      <= '0;
         r_pio_read_valid      <= 1'b0;
         r_pio_read_address    <= '0;
         r_pio_read_rid_tag    <= '0;
         r_pio_read_lower_addr <= '0;
         r_cpl_valid           <= 1'b0;
         r_cpl_data            <= '0;
         r_cpl_tag             <= '0;
         r_cpl_index           <= '0;
         r_cpl_last            <= 1'b0;
         r_cpl_error           <= 1'b0;
         r_unsupported_count   <= '0;
      end else begin
         r_tready          <= 1'b1;
         r_pio_write_valid <= 1'b0;
         r_pio_read_valid  <= 1'b0;
         r_cpl_valid       <= 1'b0;
         r_cpl_last        <= 1'b0;
         r_cpl_error       <= 1'b0;

         if (w_beat) begin
            unique case (r_state)
               S_IDLE: begin
                  if (w_is_mem && w_len_ok) begin
                     if (axis_rx_tlast) begin
                        r_unsupported_count <= sat_inc(r_unsupported_count);
                     end else begin
                        r_is_wr   <= w_fmt_type[6];
                        r_is_4dw  <= w_fmt_type[5];
                        r_len1    <= (w_len == 10'd1);
                        r_rid_tag <= {w_dw1[31:16], w_dw1[15:8]};
                        r_state   <= S_HDR;
                     end
                  end else if (w_is_cpld) begin
                     if (axis_rx_tlast) begin
                        r_unsupported_count <= sat_inc(r_unsupported_count);
                     end else begin
                        r_rem   <= w_len - 10'd1;
                        r_index <= w_cpl_index;
                        r_state <= S_CPL_HDR;
                     end
                  end else begin
                     r_unsupported_count <= sat_inc(r_unsupported_count);
                     r_state <= axis_rx_tlast ? S_IDLE : S_DROP;
                  end
               end

               S_HDR: begin
                  r_addr <= w_hdr_qaddr;
                  if (!r_is_wr) begin
                     r_pio_read_valid      <= 1'b1;
                     r_pio_read_address    <= w_hdr_qaddr;
                     r_pio_read_rid_tag    <= r_rid_tag;
                     r_pio_read_lower_addr <= w_hdr_qaddr[3:0];
                     r_state <= axis_rx_tlast ? S_IDLE : S_DROP;
                  end else if (!r_is_4dw && r_len1) begin
                     // MWr32 of one DW: the data rides in beat1 with the address.
                     r_pio_write_valid   <= 1'b1;
                     r_pio_write_address <= w_hdr_qaddr;
                     r_pio_write_data    <= {32'd0, swap32(w_dw1)};
                     r_state <= axis_rx_tlast ? S_IDLE : S_DROP;
                  end else if (axis_rx_tlast) begin
                     r_unsupported_count <= sat_inc(r_unsupported_count);
                     r_state <= S_IDLE;
                  end else begin
                     r_wdata0 <= w_dw1;
                     r_state  <= S_WDATA;
                  end
               end

               S_WDATA: begin
                  // Every supported write finishes its data in exactly one beat here.
                  r_pio_write_valid   <= 1'b1;
                  r_pio_write_address <= r_addr;
                  if (r_is_4dw) begin
                     r_pio_write_data <= {r_len1 ? 32'd0 : swap32(w_dw1), swap32(w_dw0)};
                  end else begin
                     r_pio_write_data <= {swap32(w_dw0), swap32(r_wdata0)};
                  end
                  r_state <= axis_rx_tlast ? S_IDLE : S_DROP;
               end

               S_CPL_HDR: begin
                  if (axis_rx_tlast) begin
                     r_unsupported_count <= sat_inc(r_unsupported_count);
                     r_state <= S_IDLE;
                  end else begin
                     r_tag   <= w_dw0[15:8];
                     r_held  <= w_dw1;
                     r_state <= S_CPL_DATA;
                  end
               end

               S_CPL_DATA: begin
                  // r_rem counts DWs still to arrive beyond the held one; it is
                  // odd, so 1 means this beat closes the completion.
                  if (axis_rx_tlast && (r_rem > 10'd2)) begin
                     r_cpl_error <= 1'b1;
                     r_state     <= S_IDLE;
                  end else begin
                     r_cpl_valid <= 1'b1;
                     r_cpl_data  <= {swap32(w_dw0), swap32(r_held)};
                     r_cpl_tag   <= r_tag;
                     r_cpl_index <= r_index;
                     r_index     <= r_index + 6'd1;
                     r_held      <= w_dw1;
                     if (r_rem <= 10'd2) begin
                        r_cpl_last <= 1'b1;
                        r_rem      <= '0;
                        r_state    <= axis_rx_tlast ? S_IDLE : S_DROP;
                     end else begin
                        r_rem <= r_rem - 10'd2;
                     end
                  end
               end

               S_DROP: begin
                  if (axis_rx_tlast) r_state <= S_IDLE;
               end

               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign axis_rx_tready      = r_tready;
   assign pio_write_valid     = r_pio_write_valid;
   assign pio_write_address   = r_pio_write_address;
   assign pio_write_data      = r_pio_write_data;
   assign pio_read_valid      = r_pio_read_valid;
   assign pio_read_address    = r_pio_read_address;
   assign pio_read_rid_tag    = r_pio_read_rid_tag;
   assign pio_read_lower_addr = r_pio_read_lower_addr;
   assign cpl_valid           = r_cpl_valid;
   assign cpl_data            = r_cpl_data;
   assign cpl_tag             = r_cpl_tag;
   assign cpl_index           = r_cpl_index;
   assign cpl_last            = r_cpl_last;
   assign cpl_error           = r_cpl_error;
   assign unsupported_count   = r_unsupported_count;

endmodule

// File: tb/tb_pcie_rx.sv
// -----------------------------------------------------------------------------
// tb_pcie_rx
//   Scoreboard bench for pcie_rx. TLPs are built as DW lists; the expected
//   PIO / completion events are derived from the TLP contents and queued as
//   packed signatures, and a negedge monitor pops and compares them whenever
//   the DUT strobes an output.
// -----------------------------------------------------------------------------
module tb_pcie_rx;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        axis_rx_tvalid = 1'b0;
   logic [63:0] axis_rx_tdata = '0;
   logic        axis_rx_tlast = 1'b0;
   logic        axis_rx_tready;
   logic        pio_write_valid;
   logic [12:0] pio_write_address;
   logic [63:0] pio_write_data;
   logic        pio_read_valid;
   logic [12:0] pio_read_address;
   logic [23:0] pio_read_rid_tag;
   logic [3:0]  pio_read_lower_addr;
   logic        cpl_valid;
   logic [63:0] cpl_data;
   logic [7:0]  cpl_tag;
   logic [5:0]  cpl_index;
   logic        cpl_last;
   logic        cpl_error;
   logic [7:0]  unsupported_count;

   pcie_rx #(.READ_REQUEST_BYTES(512)) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .axis_rx_tvalid      (axis_rx_tvalid),
      .axis_rx_tdata       (axis_rx_tdata),
      .axis_rx_tlast       (axis_rx_tlast),
      .axis_rx_tready      (axis_rx_tready),
      .pio_write_valid     (pio_write_valid),
      .pio_write_address   (pio_write_address),
      .pio_write_data      (pio_write_data),
      .pio_read_valid      (pio_read_valid),
      .pio_read_address    (pio_read_address),
      .pio_read_rid_tag    (pio_read_rid_tag),
      .pio_read_lower_addr (pio_read_lower_addr),
      .cpl_valid           (cpl_valid),
      .cpl_data            (cpl_data),
      .cpl_tag             (cpl_tag),
      .cpl_index           (cpl_index),
      .cpl_last            (cpl_last),
      .cpl_error           (cpl_error),
      .unsupported_count   (unsupported_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int model_cnt = 0;

   logic [99:0] exp_q[$];
   logic [31:0] tlp[$];

   function automatic logic [31:0] swap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   // Signatures: kind (1 write, 2 read, 3 cpl data, 4 cpl error) + fields.
   function automatic logic [99:0] wr_sig(input logic [12:0] a, input logic [63:0] d);
      return {4'd1, d, 19'd0, a};
   endfunction
   function automatic logic [99:0] rd_sig(input logic [12:0] a, input logic [23:0] rt,
                                          input logic [3:0] lo);
      return {4'd2, 23'd0, rt, lo, a, 32'd0};
   endfunction
   function automatic logic [99:0] cpl_sig(input logic [63:0] d, input logic [7:0] tg,
                                           input logic [5:0] ix, input logic lst);
      return {4'd3, d, 17'd0, lst, tg, ix};
   endfunction
   function automatic logic [99:0] err_sig();
      return {4'd4, 96'd0};
   endfunction

   function automatic logic [31:0] hdr0(input logic [6:0] ft, input logic [9:0] len);
      return {1'b0, ft, 14'd0, len};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic sb_pop(input string nm, input logic [99:0] act);
      logic [99:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected actual=%h", nm, act);
      end else begin
         e = exp_q.pop_front();
         if (e !== act) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, e);
         end
      end
   endtask

   always @(negedge clock) begin
      if (reset_n) begin
         if (pio_write_valid)
            sb_pop("pio_write", wr_sig(pio_write_address, pio_write_data));
         if (pio_read_valid)
            sb_pop("pio_read", rd_sig(pio_read_address, pio_read_rid_tag, pio_read_lower_addr));
         if (cpl_valid)
            sb_pop("cpl_data", cpl_sig(cpl_data, cpl_tag, cpl_index, cpl_last));
         if (cpl_error)
            sb_pop("cpl_error", err_sig());
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // One beat; inputs change 1 time unit after the rising edge.
   task automatic drive(input logic [63:0] d, input logic l, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            axis_rx_tvalid = 1'b0;
            axis_rx_tdata  = {$urandom, $urandom};
            axis_rx_tlast  = 1'($urandom);
            @(posedge clock); #1;
         end
      end
      axis_rx_tvalid = 1'b1;
      axis_rx_tdata  = d;
      axis_rx_tlast  = l;
      @(posedge clock); #1;
      axis_rx_tvalid = 1'b0;
      axis_rx_tlast  = 1'b0;
   endtask

   // Sends tlp[] packed two DWs per beat. trunc>0 ends the TLP after that many
   // beats; extra>0 appends junk beats before tlast.
   task automatic send(input int trunc, input int extra, input bit gaps);
      int n;
      logic [31:0] hi;
      n = (trunc > 0) ? trunc : (tlp.size() + 1) / 2;
      for (int i = 0; i < n; i++) begin
         hi = (2 * i + 1 < tlp.size()) ? tlp[2 * i + 1] : $urandom;
         drive({hi, tlp[2 * i]}, (i == n - 1) && (extra == 0), gaps);
      end
      for (int e = 0; e < extra; e++) drive({$urandom, $urandom}, e == extra - 1, gaps);
   endtask

   task automatic mwr(input bit is64, input logic [63:0] addr, input int len,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input bit gaps, input bit push);
      tlp.delete();
      tlp.push_back(hdr0(is64 ? 7'h60 : 7'h40, 10'(len)));
      tlp.push_back(32'h0000_00FF);
      if (is64) tlp.push_back(addr[63:32]);
      tlp.push_back(addr[31:0]);
      tlp.push_back(d0);
      if (len == 2) tlp.push_back(d1);
      if (push) exp_q.push_back(wr_sig(addr[15:3], {(len == 2) ? swap(d1) : 32'd0, swap(d0)}));
      send(0, 0, gaps);
   endtask

   task automatic mrd(input bit is64, input logic [63:0] addr, input int len,
                      input logic [15:0] rid, input logic [7:0] tag,
                      input bit gaps, input int extra, input bit push);
      tlp.delete();
      tlp.push_back(hdr0(is64 ? 7'h20 : 7'h00, 10'(len)));
      tlp.push_back({rid, tag, 8'hFF});
      if (is64) tlp.push_back(addr[63:32]);
      tlp.push_back(addr[31:0]);
      if (push) exp_q.push_back(rd_sig(addr[15:3], {rid, tag}, addr[6:3]));
      send(0, extra, gaps);
   endtask

   // Completion data: DW k is k when count_pattern, else random.
   task automatic cpld(input logic [7:0] tag, input int len, input int bc,
                       input bit count_pattern, input int trunc, input bit gaps);
      logic [31:0] d[$];
      int base, nq;
      d.delete();
      for (int k = 0; k < len; k++) d.push_back(count_pattern ? 32'(k) : $urandom);
      tlp.delete();
      tlp.push_back(hdr0(7'h4A, 10'(len)));
      tlp.push_back({16'h0001, 3'b000, 1'b0, 12'(bc)});
      tlp.push_back({16'h0000, tag, 8'h00});
      for (int k = 0; k < len; k++) tlp.push_back(d[k]);
      base = ((512 - bc) >> 3) & 63;
      nq = (trunc > 0) ? trunc - 3 : len / 2;
      for (int q = 0; q < nq; q++)
         exp_q.push_back(cpl_sig({swap(d[2 * q + 1]), swap(d[2 * q])}, tag,
                                 6'((base + q) & 63), (trunc == 0) && (q == nq - 1)));
      if (trunc > 0) exp_q.push_back(err_sig());
      send(trunc, 0, gaps);
   endtask

   task automatic unsup(input logic [31:0] dw0, input logic [31:0] dw1,
                        input int nbeats, input bit gaps);
      tlp.delete();
      tlp.push_back(dw0);
      tlp.push_back(dw1);
      while (tlp.size() < 2 * nbeats) tlp.push_back($urandom);
      if (model_cnt < 255) model_cnt++;
      send(0, 0, gaps);
   endtask

   task automatic unsup_random(input bit gaps);
      int pick;
      int nb;
      pick = $urandom_range(0, 4);
      nb = $urandom_range(1, 4);
      case (pick)
         0: unsup(hdr0(7'h72, 10'd2), $urandom, nb, gaps);
         1: unsup(hdr0(7'h0A, 10'd0), $urandom, nb, gaps);
         2: unsup(hdr0(7'h4A, 10'd4), {16'h1, 3'b001, 13'h0100}, nb, gaps);
         3: unsup(hdr0(7'h4A, 10'd5), {16'h1, 3'b000, 13'h0100}, nb, gaps);
         default: unsup(hdr0(7'h40, 10'd3), $urandom, nb, gaps);
      endcase
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset state
      #22;
      chk("reset_outputs",
          64'({axis_rx_tready, pio_write_valid, pio_read_valid, cpl_valid, cpl_last,
               cpl_error, unsupported_count} | {6'd0, |pio_write_data, |cpl_data,
               |pio_write_address, |pio_read_address, |pio_read_rid_tag,
               |pio_read_lower_addr, |cpl_tag, |cpl_index}), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("tready_before_edge", 64'(axis_rx_tready), 64'd0);
      @(posedge clock); #1;
      chk("tready_after_edge", 64'(axis_rx_tready), 64'd1);
      idle(2);

      // Directed cases with constant expectations
      exp_q.push_back(wr_sig(13'd9, 64'h8877665544332211));
      mwr(1'b0, 64'h48, 2, 32'h11223344, 32'h55667788, 1'b0, 1'b0);
      idle(3);
      exp_q.push_back(rd_sig(13'd10, 24'h010007, 4'hA));
      mrd(1'b1, 64'h1_0000_0050, 2, 16'h0100, 8'h07, 1'b0, 0, 1'b0);
      idle(3);
      exp_q.push_back(cpl_sig({swap(32'd1), swap(32'd0)}, 8'h03, 6'd0, 1'b0));
      for (int q = 1; q < 8; q++)
         exp_q.push_back(cpl_sig({swap(32'(2 * q + 1)), swap(32'(2 * q))}, 8'h03,
                                 6'(q), q == 7));
      tlp.delete();
      tlp.push_back(hdr0(7'h4A, 10'd16));
      tlp.push_back({16'h0001, 4'b0000, 12'd512});
      tlp.push_back({16'h0000, 8'h03, 8'h00});
      for (int k = 0; k < 16; k++) tlp.push_back(32'(k));
      send(0, 0, 1'b0);
      idle(3);

      // Model-driven directed cases, also with gaps
      cpld(8'h21, 32, 256, 1'b1, 0, 1'b0);
      cpld(8'h22, 32, 256, 1'b0, 0, 1'b1);
      cpld(8'h05, 16, 512, 1'b1, 4, 1'b0);
      cpld(8'h06, 16, 512, 1'b0, 6, 1'b1);
      mrd(1'b0, 64'h0000_1238, 1, 16'hABCD, 8'h5A, 1'b0, 2, 1'b1);
      mwr(1'b0, 64'h0000_0010, 1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1);
      mwr(1'b1, 64'h0_0000_7FF8, 1, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1);
      mwr(1'b1, 64'h3_0000_0100, 2, 32'h01020304, 32'hA0B0C0D0, 1'b1, 1'b1);
      idle(4);

      // Count a few drops, then reset in the middle of a write
      model_cnt = 0;
      for (int i = 0; i < 3; i++) unsup(hdr0(7'h72, 10'd1), 32'h0, 2, 1'b0);
      idle(2);
      chk("count_before_reset", 64'(unsupported_count), 64'(model_cnt));
      tlp.delete();
      tlp.push_back(hdr0(7'h40, 10'd2));
      tlp.push_back(32'h0000_00FF);
      tlp.push_back(32'h0000_0020);
      tlp.push_back(32'h99999999);
      drive({tlp[1], tlp[0]}, 1'b0, 1'b0);
      drive({tlp[3], tlp[2]}, 1'b0, 1'b0);
      reset_n = 1'b0;
      #2;
      chk("count_in_reset", 64'(unsupported_count), 64'd0);
      chk("tready_in_reset", 64'(axis_rx_tready), 64'd0);
      idle(2);
      @(negedge clock);
      reset_n = 1'b1;
      model_cnt = 0;
      idle(2);
      mwr(1'b0, 64'h0000_0030, 2, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
      idle(3);

      // Randomized traffic
      for (int it = 0; it < 150; it++) begin
         int r;
         bit g;
         r = $urandom_range(0, 9);
         g = 1'($urandom);
         case (r)
            0, 1, 8: mwr(1'($urandom), {$urandom, $urandom}, $urandom_range(1, 2),
                         $urandom, $urandom, g, 1'b1);
            2, 3, 9: mrd(1'($urandom), {$urandom, $urandom}, $urandom_range(1, 2),
                         16'($urandom), 8'($urandom), g, 0, 1'b1);
            4, 5, 6: cpld(8'($urandom), 2 * $urandom_range(1, 8), 8 * $urandom_range(1, 64),
                          1'b0, 0, g);
            default: unsup_random(g);
         endcase
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(4);
      chk("count_random", 64'(unsupported_count), 64'(model_cnt));

      // Saturation
      for (int i = 0; i < 260; i++) unsup(hdr0(7'h72, 10'd1), 32'h0, $urandom_range(1, 2), 1'b0);
      idle(3);
      chk("count_saturated", 64'(unsupported_count), 64'(model_cnt));
      chk("count_is_255", 64'(unsupported_count), 64'd255);

      idle(10);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
